// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - synchronise, debounce and strobe one raw button line
// One shared timer serves the debounce, hold and auto-repeat windows.
module btn_conditioner #(
   parameter int DB_CYCLES     = 1000000,
   parameter int HOLD_CYCLES   = 100000000,
   parameter int REPEAT_CYCLES = 20000000,
   parameter int CNT_W         = 27
) (
   input  logic clk,
   input  logic clr,
   input  logic btn_in,
   output logic level,
   output logic press,
   output logic release_pulse,
   output logic hold,
   output logic rpt
);

   typedef enum logic [2:0] {
      IDLE,
      DB_PRESS,
      PRESSED,
      HELD,
      DB_REL
   } state_t;

   localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] timer_q, timer_d;
   logic             s1_q, s1_d;
   logic             s_q, s_d;
   logic             was_held_q, was_held_d;
   logic             level_q, level_d;
   logic             press_q, press_d;
   logic             release_q, release_d;
   logic             hold_q, hold_d;
   logic             rpt_q, rpt_d;

   always_ff @(posedge clk) begin
      if (!clr) begin
         state_q    <= IDLE;
         timer_q    <= '0;
         s1_q       <= 1'b0;
         s_q        <= 1'b0;
         was_held_q <= 1'b0;
         level_q    <= 1'b0;
         press_q    <= 1'b0;
         release_q  <= 1'b0;
         hold_q     <= 1'b0;
         rpt_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         s1_q       <= s1_d;
         s_q        <= s_d;
         was_held_q <= was_held_d;
         level_q    <= level_d;
         press_q    <= press_d;
         release_q  <= release_d;
         hold_q     <= hold_d;
         rpt_q      <= rpt_d;
      end
   end

   always_comb begin
      s1_d       = btn_in;
      s_d        = s1_q;
      state_d    = state_q;
      timer_d    = timer_q;
      was_held_d = was_held_q;
      level_d    = level_q;
      hold_d     = hold_q;
      press_d    = 1'b0;
      release_d  = 1'b0;
      rpt_d      = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (s_q) begin
               state_d = DB_PRESS;
               timer_d = '0;
            end
         end
         DB_PRESS: begin
            if (!s_q) begin
               state_d = IDLE;
            end else if (timer_q == DB_LAST) begin
               state_d = PRESSED;
               timer_d = '0;
               level_d = 1'b1;
               press_d = 1'b1;
            end else begin
               timer_d = timer_q + CNT_W'(1);
            end
         end
         PRESSED: begin
            if (!s_q) begin
               state_d    = DB_REL;
               was_held_d = 1'b0;
               timer_d    = '0;
            end else if (timer_q == HOLD_LAST) begin
               state_d = HELD;
               hold_d  = 1'b1;
               rpt_d   = 1'b1;
               timer_d = '0;
            end else begin
               timer_d = timer_q + CNT_W'(1);
            end
         end
         HELD: begin
            if (!s_q) begin
               state_d    = DB_REL;
               was_held_d = 1'b1;
               timer_d    = '0;
            end else if (timer_q == REP_LAST) begin
               rpt_d   = 1'b1;
               timer_d = '0;
            end else begin
               timer_d = timer_q + CNT_W'(1);
            end
         end
         DB_REL: begin
            // A bounce back to 1 resumes the pressed state with a fresh count.
            if (s_q) begin
               state_d = was_held_q ? HELD : PRESSED;
               timer_d = '0;
            end else if (timer_q == DB_LAST) begin
               state_d   = IDLE;
               timer_d   = '0;
               level_d   = 1'b0;
               hold_d    = 1'b0;
               release_d = 1'b1;
            end else begin
               timer_d = timer_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            timer_d = '0;
         end
      endcase
   end

   assign level         = level_q;
   assign press         = press_q;
   assign release_pulse = release_q;
   assign hold          = hold_q;
   assign rpt           = rpt_q;

endmodule
